// File: rtl/nand_gate_unit.sv
// nand_gate_unit: registered, enable-gated bitwise NAND slice of the ALU.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, clears every pipeline stage
//   a, b    WIDTH-bit operands
//   E       unit enable (1 = compute ~(a & b), 0 = force result to zero)
//   iab     registered result, PIPE_STAGES cycles after the inputs are sampled
//   valid   iab holds a result that was computed with E=1
//   zero    iab == 0        (combinational from registered iab)
//   ones    iab is all ones (combinational from registered iab)
//   parity  XOR reduction of iab (combinational from registered iab)
module nand_gate_unit #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             E,
  output logic [WIDTH-1:0] iab,
  output logic             valid,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  // Reject illegal configurations at elaboration.
  generate
    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
      $error("nand_gate_unit: WIDTH must be in 1..32");
    end
  endgenerate

  logic [WIDTH-1:0] r1_d, r1_q;
  logic             v1_d, v1_q;

  // Stage-1 next value: NAND when enabled, zero otherwise.
  always_comb begin
    r1_d = '0;
    v1_d = E;
    if (E) begin
      r1_d = ~(a & b);
    end
  end

  // Stage-1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      r1_q <= r1_d;
      v1_q <= v1_d;
    end
  end

  // Optional second stage: a plain copy of stage 1, also cleared by reset.
  generate
    if (PIPE_STAGES == 2) begin : g_pipe2
      logic [WIDTH-1:0] r2_q;
      logic             v2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          r2_q <= r1_q;
          v2_q <= v1_q;
        end
      end

      assign iab   = r2_q;
      assign valid = v2_q;
    end else if (PIPE_STAGES == 1) begin : g_pipe1
      assign iab   = r1_q;
      assign valid = v1_q;
    end else begin : g_bad_pipe
      $error("nand_gate_unit: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

  // Status flags decode the registered result directly, adding no latency.
  assign zero   = (iab == '0);
  assign ones   = (iab == '1);
  assign parity = ^iab;

endmodule

// File: tb/tb_nand_gate_unit.sv
// tb_nand_gate_unit: drives one latency-1 and one latency-2 instance from the
// same stimulus and compares both against a history of expected results.
module tb_nand_gate_unit;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         e;

  logic [W-1:0] iab1, iab2;
  logic         valid1, zero1, ones1, parity1;
  logic         valid2, zero2, ones2, parity2;

  int n_checks;
  int n_fail;

  // Expected {valid, result} history; index 0 is the most recent edge.
  logic [W:0] hist_q[$];

  nand_gate_unit #(.WIDTH(W), .PIPE_STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .E(e),
    .iab(iab1), .valid(valid1), .zero(zero1), .ones(ones1), .parity(parity1)
  );

  nand_gate_unit #(.WIDTH(W), .PIPE_STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .E(e),
    .iab(iab2), .valid(valid2), .zero(zero2), .ones(ones2), .parity(parity2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reset wipes all in-flight results.
  task automatic model_reset();
    hist_q.delete();
    hist_q.push_front({1'b0, {W{1'b0}}});
    hist_q.push_front({1'b0, {W{1'b0}}});
  endtask

  // One sampled edge: the unit either computes NAND or yields zero.
  task automatic model_edge(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic te);
    logic [W-1:0] r;
    r = te ? W'(~(ta & tb)) : W'(0);
    hist_q.push_front({te, r});
    void'(hist_q.pop_back());
  endtask

  task automatic check_unit(input string tag, input logic [W:0] exp_e,
                            input logic [W-1:0] g_iab, input logic g_valid,
                            input logic g_zero, input logic g_ones, input logic g_parity);
    logic [W-1:0] er;
    er = exp_e[W-1:0];
    check_eq({tag, ".iab"},    32'(g_iab),    32'(er));
    check_eq({tag, ".valid"},  32'(g_valid),  32'(exp_e[W]));
    check_eq({tag, ".zero"},   32'(g_zero),   32'(er == 0));
    check_eq({tag, ".ones"},   32'(g_ones),   32'(er == {W{1'b1}}));
    check_eq({tag, ".parity"}, 32'(g_parity), 32'(^er));
  endtask

  task automatic check_all(input string tag);
    check_unit({tag, ".p1"}, hist_q[0], iab1, valid1, zero1, ones1, parity1);
    check_unit({tag, ".p2"}, hist_q[1], iab2, valid2, zero2, ones2, parity2);
  endtask

  task automatic step(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic te);
    a = ta;
    b = tb;
    e = te;
    @(posedge clk);
    #1;
    model_edge(ta, tb, te);
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    e = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check_eq("reset.iab_const", 32'(iab1), 32'h0);
    rst_n = 1'b1;

    // Directed enabled/disabled cases.
    step("en_0_1", 4'h0, 4'h1, 1'b1);
    check_eq("en_0_1.iab_const", 32'(iab1), 32'hF);
    step("en_1_1", 4'h1, 4'h1, 1'b1);
    check_eq("en_1_1.iab_const", 32'(iab1), 32'hE);
    check_eq("en_0_1.p2_const", 32'(iab2), 32'hF);
    step("en_1_0", 4'h1, 4'h0, 1'b1);
    check_eq("en_1_1.p2_const", 32'(iab2), 32'hE);
    step("dis_f_f", 4'hF, 4'hF, 1'b0);
    check_eq("dis_f_f.valid_const", 32'(valid1), 32'h0);
    step("en_f_f", 4'hF, 4'hF, 1'b1);
    check_eq("en_f_f.valid_const", 32'(valid1), 32'h1);

    // Exhaustive operand sweep, back-to-back.
    for (int i = 0; i < 256; i++) begin
      step("sweep", W'(i >> 4), W'(i), 1'b1);
    end

    // Enable toggling every cycle.
    for (int i = 0; i < 12; i++) begin
      step("toggle", 4'h5, 4'h3, (i % 2) == 0);
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Mid-stream asynchronous reset with E=1, a=3, b=1.
    step("pre_rst", 4'h3, 4'h1, 1'b1);
    step("pre_rst2", 4'h3, 4'h1, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("held_rst");
    #2;
    rst_n = 1'b1;
    step("post_rst", 4'h3, 4'h1, 1'b1);
    check_eq("post_rst.iab_const", 32'(iab1), 32'hE);
    check_eq("post_rst.p2_cleared", 32'(valid2), 32'h0);
    step("post_rst2", 4'h3, 4'h1, 1'b1);
    check_eq("post_rst2.p2_const", 32'(iab2), 32'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
